// File: rtl/task_packetizer.sv
// Packs the parser's flit stream into mapper-bound NoC packets: header, size, payload.
// Define TASK_PACKETIZER_CHECKSUM_EN to append an XOR checksum flit after the payload.
module task_packetizer #(
  parameter int FLIT_SIZE   = 32,
  parameter int MAX_PAYLOAD = 16,
  parameter int IDLE_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 eoa_i,
  input  logic [15:0]          target_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 busy_o
);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] FULL     = CW'(MAX_PAYLOAD);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  typedef enum logic [2:0] {
    FILL,
    SEND_HEADER,
    SEND_SIZE,
    SEND_PAYLOAD
`ifdef TASK_PACKETIZER_CHECKSUM_EN
    , SEND_CHECKSUM
`endif
  } state_t;

  state_t               state, nxt;
  logic [CW-1:0]        count, rd_ptr;
  logic [IW-1:0]        idle_cnt;
  logic [15:0]          target_q;
  logic [FLIT_SIZE-1:0] pbuf [MAX_PAYLOAD];
  logic [FLIT_SIZE-1:0] size_flit;
  logic                 accept, flush, last, done;
`ifdef TASK_PACKETIZER_CHECKSUM_EN
  logic [FLIT_SIZE-1:0] csum;
  assign size_flit = FLIT_SIZE'(count) + FLIT_SIZE'(1);
`else
  assign size_flit = FLIT_SIZE'(count);
`endif

  assign accept = rx_i && credit_o;
  assign flush  = (count == FULL) ||
                  ((count != '0) && (idle_cnt == IDLE_MAX)) ||
                  ((count != '0) && eoa_i);
  assign last   = (rd_ptr == count - CW'(1));
  // Any SEND_* -> FILL transition is the end of the packet.
  assign done   = (state != FILL) && (nxt == FILL);
  assign busy_o = (count != '0) || (state != FILL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= FILL;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      FILL:         if (flush)    nxt = SEND_HEADER;
      SEND_HEADER:  if (credit_i) nxt = SEND_SIZE;
      SEND_SIZE:    if (credit_i) nxt = SEND_PAYLOAD;
`ifdef TASK_PACKETIZER_CHECKSUM_EN
      SEND_PAYLOAD:  if (credit_i && last) nxt = SEND_CHECKSUM;
      SEND_CHECKSUM: if (credit_i)         nxt = FILL;
`else
      SEND_PAYLOAD:  if (credit_i && last) nxt = FILL;
`endif
      default:      nxt = FILL;
    endcase
  end

  always_comb begin
    credit_o = 1'b0;
    tx_o     = 1'b0;
    data_o   = '0;
    unique case (state)
      FILL:         credit_o = (count < FULL);
      SEND_HEADER:  begin tx_o = 1'b1; data_o = FLIT_SIZE'(target_q); end
      SEND_SIZE:    begin tx_o = 1'b1; data_o = size_flit; end
      SEND_PAYLOAD: begin tx_o = 1'b1; data_o = pbuf[rd_ptr[AW-1:0]]; end
`ifdef TASK_PACKETIZER_CHECKSUM_EN
      SEND_CHECKSUM: begin tx_o = 1'b1; data_o = csum; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count    <= '0;
      rd_ptr   <= '0;
      idle_cnt <= '0;
      target_q <= '0;
`ifdef TASK_PACKETIZER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else if (done) begin
      count    <= '0;
      rd_ptr   <= '0;
      idle_cnt <= '0;
`ifdef TASK_PACKETIZER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (state == FILL) begin
        if (accept) begin
          count    <= count + CW'(1);
          idle_cnt <= '0;
`ifdef TASK_PACKETIZER_CHECKSUM_EN
          csum     <= csum ^ data_i;
`endif
        end else if ((count != '0) && (idle_cnt != IDLE_MAX)) begin
          idle_cnt <= idle_cnt + IW'(1);
        end
        if (flush) target_q <= target_i;
      end
      if ((state == SEND_PAYLOAD) && credit_i) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Payload storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (accept) pbuf[count[AW-1:0]] <= data_i;
  end
endmodule
